neuron_mac_seq: RTL and testbench

Parametrised, time-multiplexed fully-connected neuron for the ECG inference layers. It accepts one activation per beat over a valid/ready stream and multiplies it by a per-index weight held in an internal, runtime-loadable weight file. It accumulates a full frame of N_IN products, adds a bias, rescales by FRAC, then saturates and applies a selectable activation (ReLU or linear). The block replaces per-node fixed-weight parallel multipliers with one multiplier per neuron, so layer width no longer sets multiplier count.

---
 rtl/neuron_mac_seq.sv | 147 ++++++++++++++
 tb/tb_neuron_mac_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// rtl/neuron_mac_seq.sv - time-multiplexed fully-connected neuron: streamed MAC, bias, rescale, saturate, ReLU
// One multiplier walks the frame; the weight file and bias are writable at any time.
module neuron_mac_seq #(
    parameter int N_IN = 30,
    parameter int DW   = 16,
    parameter int WW   = 16,
    parameter int FRAC = 8,
    parameter int ACCW = 48,
    parameter int AW   = $clog2(N_IN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 w_we,
    input  logic [AW-1:0]        w_addr,
    input  logic signed [WW-1:0] w_data,
    input  logic                 act_relu,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_sat,
    output logic                 out_err
);
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PW = DW + WW;
    localparam logic signed [ACCW-1:0] MAX_V = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] MIN_V = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_FIN = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic signed [ACCW-1:0] acc;
    logic signed [WW-1:0]   weights [N_IN];
    logic signed [WW-1:0]   bias;
    logic                   relu_q;
    logic                   err_q;

    logic                   first_beat;
    logic                   last_idx;
    logic signed [PW-1:0]   product;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [ACCW-1:0] bias_ext;
    logic signed [ACCW-1:0] t_sum;
    logic signed [ACCW-1:0] s_val;
    logic signed [DW-1:0]   clip_val;
    logic                   clip_sat;
    logic signed [DW-1:0]   res_val;
    logic                   err_next;

    assign in_ready   = (state == ST_ACC);
    assign first_beat = (idx == '0);
    assign last_idx   = (idx == IW'(N_IN - 1));

    // Weight read sees the pre-write value, so a same-cycle write lands on the next frame's beat.
    assign product  = in_data * weights[idx];
    assign prod_ext = {{(ACCW-PW){product[PW-1]}}, product};
    assign err_next = (first_beat ? 1'b0 : err_q) | (in_last ^ last_idx);

    // Bias is aligned to the product's Q(2*FRAC) before the arithmetic rescale.
    assign bias_ext = {{(ACCW-WW){bias[WW-1]}}, bias} <<< FRAC;
    assign t_sum    = acc + bias_ext;
    assign s_val    = t_sum >>> FRAC;

    always_comb begin
        clip_val = s_val[DW-1:0];
        clip_sat = 1'b0;
        if (s_val > MAX_V) begin
            clip_val = MAX_V[DW-1:0];
            clip_sat = 1'b1;
        end else if (s_val < MIN_V) begin
            clip_val = MIN_V[DW-1:0];
            clip_sat = 1'b1;
        end
        res_val = clip_val;
        if (relu_q && clip_val[DW-1]) begin
            res_val = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_ACC;
            idx       <= '0;
            acc       <= '0;
            bias      <= '0;
            relu_q    <= 1'b0;
            err_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_err   <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                weights[i] <= '0;
            end
        end else begin
            if (w_we) begin
                if (w_addr < AW'(N_IN)) begin
                    weights[w_addr[IW-1:0]] <= w_data;
                end else if (w_addr == AW'(N_IN)) begin
                    bias <= w_data;
                end
            end

            case (state)
                ST_ACC: begin
                    if (in_valid) begin
                        acc   <= first_beat ? prod_ext : acc + prod_ext;
                        err_q <= err_next;
                        if (first_beat) begin
                            relu_q <= act_relu;
                        end
                        if (last_idx) begin
                            idx   <= '0;
                            state <= ST_FIN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    out_data  <= res_val;
                    out_sat   <= clip_sat;
                    out_err   <= err_q;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACC;
                    end
                end
                default: begin
                    state <= ST_ACC;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb/tb_neuron_mac_seq.sv - table-driven and randomized checks of neuron_mac_seq against an arithmetic model
module tb_neuron_mac_seq;
    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int WW   = 16;
    localparam int FRAC = 8;
    localparam int AW   = $clog2(N + 1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 w_we;
    logic [AW-1:0]        w_addr;
    logic signed [WW-1:0] w_data;
    logic                 act_relu;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_sat;
    logic                 out_err;

    neuron_mac_seq #(.N_IN(N), .DW(DW), .WW(WW), .FRAC(FRAC)) dut (
        .clk(clk), .reset(reset), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .act_relu(act_relu), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .out_err(out_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int m_w [N];
    int m_bias;

    typedef struct packed {
        int                  w;
        int                  bias;
        bit                  relu;
        logic [N-1:0][15:0]  din;
        logic [N-1:0]        lasts;
        int                  ed;
        int                  es;
        int                  ee;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int addr, input int data);
        logic [15:0] d16;
        d16    = data[15:0];
        w_we   = 1'b1;
        w_addr = addr[AW-1:0];
        w_data = d16;
        step();
        w_we = 1'b0;
        if (addr < N) m_w[addr] = int'($signed(d16));
        else if (addr == N) m_bias = int'($signed(d16));
    endtask

    task automatic load_uniform(input int w, input int b);
        for (int i = 0; i < N; i++) wr(i, w);
        wr(N, b);
    endtask

    // Expected result from the arithmetic definition: dot product, biased, floor-rescaled, clipped, ReLU.
    task automatic model(input int din [N], input bit [N-1:0] lasts, input bit relu,
                         output int d, output int s, output int e);
        longint sum;
        sum = 0;
        for (int i = 0; i < N; i++) sum += longint'(din[i]) * longint'(m_w[i]);
        sum += longint'(m_bias) * (longint'(1) << FRAC);
        sum = sum >>> FRAC;
        s = 0;
        if (sum > 32767) begin sum = 32767; s = 1; end
        else if (sum < -32768) begin sum = -32768; s = 1; end
        d = (relu && sum < 0) ? 0 : int'(sum);
        e = 0;
        for (int i = 0; i < N; i++) if (lasts[i] != (i == N - 1)) e = 1;
    endtask

    task automatic send_frame(input int din [N], input bit [N-1:0] lasts, input bit relu,
                              input bit gaps, input int wr_beat, input int wa, input int wd);
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0;
                    act_relu = 1'($urandom);
                    step();
                end
            end
            in_valid = 1'b1;
            in_data  = din[i][15:0];
            in_last  = lasts[i];
            act_relu = (i == 0) ? relu : 1'($urandom);
            if (i == wr_beat) begin
                w_we   = 1'b1;
                w_addr = wa[AW-1:0];
                w_data = wd[15:0];
            end
            check($sformatf("in_ready_beat%0d", i), int'(in_ready), 1);
            step();
            w_we     = 1'b0;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    // Called right after the last beat's edge; result must appear exactly one edge later.
    task automatic get_result(input string name, input int ed, input int es, input int ee);
        check({name, "_fin_valid"}, int'(out_valid), 0);
        check({name, "_fin_ready"}, int'(in_ready), 0);
        out_ready = 1'b1;
        step();
        check({name, "_valid"}, int'(out_valid), 1);
        check({name, "_data"}, int'(out_data), ed);
        check({name, "_sat"}, int'(out_sat), es);
        check({name, "_err"}, int'(out_err), ee);
        step();
        check({name, "_done_valid"}, int'(out_valid), 0);
        check({name, "_done_ready"}, int'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    initial begin
        int din [N];
        int ed, es, ee;
        bit [N-1:0] lasts;
        bit relu;

        reset = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0; act_relu = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < N; i++) m_w[i] = 0;
        m_bias = 0;
        repeat (3) step();
        reset = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_sat", int'(out_sat), 0);
        check("rst_out_err", int'(out_err), 0);

        vecs[0] = '{256, 128, 1'b1, {16'hFF00, 16'd768, 16'd512, 16'd256}, 4'b1000, 1408, 0, 0};
        vecs[1] = '{256, 0, 1'b1, {16'hFC00, 16'hFD00, 16'hFE00, 16'hFF00}, 4'b1000, 0, 0, 0};
        vecs[2] = '{256, 0, 1'b0, {16'hFC00, 16'hFD00, 16'hFE00, 16'hFF00}, 4'b1000, -2560, 0, 0};
        vecs[3] = '{32767, 0, 1'b0, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 4'b1000, 32767, 1, 0};
        vecs[4] = '{32767, 0, 1'b0, {16'h8000, 16'h8000, 16'h8000, 16'h8000}, 4'b1000, -32768, 1, 0};
        vecs[5] = '{256, 0, 1'b0, {16'd256, 16'd256, 16'd256, 16'd256}, 4'b0010, 1024, 0, 1};
        vecs[6] = '{256, 0, 1'b0, {16'd256, 16'd256, 16'd256, 16'd256}, 4'b1000, 1024, 0, 0};

        for (int v = 0; v < 7; v++) begin
            load_uniform(vecs[v].w, vecs[v].bias);
            for (int i = 0; i < N; i++) din[i] = int'($signed(vecs[v].din[i]));
            send_frame(din, vecs[v].lasts, vecs[v].relu, 1'b0, -1, 0, 0);
            get_result($sformatf("vec%0d", v), vecs[v].ed, vecs[v].es, vecs[v].ee);
        end

        // Consumer back-pressure: result held, input beats ignored.
        din = '{256, 256, 256, 256};
        send_frame(din, 4'b1000, 1'b0, 1'b0, -1, 0, 0);
        step();
        check("hold_valid0", int'(out_valid), 1);
        check("hold_data0", int'(out_data), 1024);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            in_last  = 1'($urandom);
            step();
            check($sformatf("hold_valid%0d", k + 1), int'(out_valid), 1);
            check($sformatf("hold_data%0d", k + 1), int'(out_data), 1024);
            check($sformatf("hold_ready%0d", k + 1), int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        step();
        check("hold_release_valid", int'(out_valid), 0);
        check("hold_release_ready", int'(in_ready), 1);
        out_ready = 1'b0;
        din = '{256, 512, 768, -256};
        model(din, 4'b1000, 1'b0, ed, es, ee);
        send_frame(din, 4'b1000, 1'b0, 1'b0, -1, 0, 0);
        get_result("after_hold", ed, es, ee);

        // Reset mid-frame clears partial sum and the weight file.
        load_uniform(256, 128);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 16'd1000;
            in_last  = 1'b0;
            step();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_w[i] = 0;
        m_bias = 0;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_ready", int'(in_ready), 1);
        din = '{256, 512, 768, -256};
        send_frame(din, 4'b1000, 1'b1, 1'b0, -1, 0, 0);
        get_result("midrst_noload", 0, 0, 0);
        load_uniform(256, 128);
        send_frame(din, 4'b1000, 1'b1, 1'b0, -1, 0, 0);
        get_result("midrst_reload", 1408, 0, 0);

        // Write to W[1] on the edge that consumes beat 1.
        load_uniform(256, 0);
        din = '{256, 256, 256, 256};
        send_frame(din, 4'b1000, 1'b0, 1'b0, 1, 1, 512);
        get_result("wr_same_beat", 1024, 0, 0);
        m_w[1] = 512;
        send_frame(din, 4'b1000, 1'b0, 1'b0, -1, 0, 0);
        get_result("wr_next_frame", 1280, 0, 0);

        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 4)) begin
                if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 7), int'($urandom));
                else wr($urandom_range(0, N), $urandom_range(0, 1023) - 512);
            end
            for (int i = 0; i < N; i++) begin
                din[i] = ($urandom_range(0, 3) == 0) ? int'($signed(16'($urandom)))
                                                     : $urandom_range(0, 4095) - 2048;
            end
            lasts = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b1000;
            relu  = 1'($urandom);
            model(din, lasts, relu, ed, es, ee);
            send_frame(din, lasts, relu, 1'($urandom), -1, 0, 0);
            get_result($sformatf("rnd%0d", f), ed, es, ee);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
